// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - writeback stage types and constants
package wb_pkg;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_LINK = 2'd2,
        KIND_NONE = 2'd3
    } kind_e;

    typedef enum logic [2:0] {
        LT_LB  = 3'd0,
        LT_LBU = 3'd1,
        LT_LH  = 3'd2,
        LT_LHU = 3'd3,
        LT_LW  = 3'd4
    } ltype_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_e;

    localparam logic [31:0] LINK_OFFSET = 32'd8;

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - little-endian sub-word select and extend for loads
module load_extract
    import wb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  ltype,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Codes 5-7 fall into the default and behave as LW.
    always_comb begin
        data = word;
        case (ltype)
            LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  data = {24'd0, byte_sel};
            LT_LH:   data = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - writeback stage with load wait and timeout; WB_SUBWORD_EN enables sub-word load extraction
module writeback_stage
    import wb_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [4:0]       in_dest,
    input  logic [31:0]      in_result,
    input  logic [31:0]      in_pc,
    input  logic [2:0]       in_ltype,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             write,
    output logic [4:0]       reg_write_address,
    output logic [31:0]      write_data,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

    state_e        state;
    logic [TW-1:0] wait_cnt;
    logic [4:0]    ld_dest;
    logic [31:0]   load_data;

    assign in_ready = (state == ST_IDLE);

`ifdef WB_SUBWORD_EN
    logic [1:0] ld_offset;
    logic [2:0] ld_ltype;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_offset <= 2'd0;
            ld_ltype  <= 3'd0;
        end else if (in_valid && in_ready && kind_e'(in_kind) == KIND_LOAD) begin
            ld_offset <= in_result[1:0];
            ld_ltype  <= in_ltype;
        end
    end

    load_extract u_load_extract (
        .word   (mem_rdata),
        .offset (ld_offset),
        .ltype  (ld_ltype),
        .data   (load_data)
    );
`else
    logic unused_ltype;
    assign unused_ltype = ^in_ltype;
    assign load_data    = mem_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            wait_cnt          <= '0;
            ld_dest           <= 5'd0;
            write             <= 1'b0;
            reg_write_address <= 5'd0;
            write_data        <= 32'd0;
            mem_err           <= 1'b0;
            stall_cycles      <= '0;
        end else begin
            write   <= 1'b0;
            mem_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        case (kind_e'(in_kind))
                            KIND_ALU: if (in_dest != 5'd0) begin
                                write             <= 1'b1;
                                reg_write_address <= in_dest;
                                write_data        <= in_result;
                            end
                            KIND_LINK: if (in_dest != 5'd0) begin
                                write             <= 1'b1;
                                reg_write_address <= in_dest;
                                write_data        <= in_pc + LINK_OFFSET;
                            end
                            KIND_LOAD: begin
                                ld_dest  <= in_dest;
                                wait_cnt <= '0;
                                state    <= ST_WAIT_MEM;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WAIT_MEM: begin
                    if (stall_cycles != '1)
                        stall_cycles <= stall_cycles + CNT_W'(1);
                    // Data arriving in the final wait cycle still completes the load.
                    if (mem_rvalid) begin
                        state <= ST_IDLE;
                        if (ld_dest != 5'd0) begin
                            write             <= 1'b1;
                            reg_write_address <= ld_dest;
                            write_data        <= load_data;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= ST_IDLE;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 64: max cycles in WAIT_MEM before the load is abandoned.
REQ-002 SHALL have parameter CNT_W, default 16: width of stall_cycles.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream (MEM stage) instruction valid.
REQ-006 in_ready  output  1  stage can accept; transfer = in_valid && in_ready.
REQ-007 in_kind  input  2  0 ALU, 1 LOAD, 2 LINK, 3 NONE.
REQ-008 in_dest  input  5  destination register number.
REQ-009 in_result  input  32  ALU value, or load byte address.
REQ-010 in_pc  input  32  instruction PC (LINK only).
REQ-011 in_ltype  input  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW; 5-7 treated as LW.
REQ-012 mem_rvalid  input  1  data-memory read data valid.
REQ-013 mem_rdata  input  32  data-memory read word.
REQ-014 write  output  1  register-file write enable, one-cycle pulse per writeback.
REQ-015 reg_write_address  output  5  register-file write address.
REQ-016 write_data  output  32  register-file write data.
REQ-017 mem_err  output  1  one-cycle pulse on load timeout.
REQ-018 stall_cycles  output  CNT_W  saturating count of WAIT_MEM cycles.

Function
REQ-019 SHALL implement FSM states IDLE and WAIT_MEM; in_ready = (state == IDLE), combinational.
REQ-020 ALU accepted: next cycle write=1, reg_write_address=in_dest, write_data=in_result.
REQ-021 LINK accepted: next cycle write=1, write_data=in_pc+8 (mod 2^32).
REQ-022 NONE accepted: no write; state stays IDLE.
REQ-023 in_dest==0: write SHALL stay 0 for every kind; LOAD still enters WAIT_MEM.
REQ-024 LOAD accepted: latch in_dest, in_result[1:0], in_ltype; go to WAIT_MEM; mem_rvalid first sampled the cycle after accept.
REQ-025 WAIT_MEM with mem_rvalid=1: next cycle write pulse with extracted data; state -> IDLE; in_ready high from that cycle.
REQ-026 mem_rvalid while IDLE SHALL be ignored.
REQ-027 Wait counter clears on LOAD accept; after MEM_TIMEOUT WAIT_MEM cycles without mem_rvalid: state -> IDLE, no write, mem_err=1 next cycle.
REQ-028 mem_rvalid in the timeout cycle SHALL win: normal write, no mem_err.
REQ-029 stall_cycles increments each WAIT_MEM cycle, saturates at all-ones, never wraps.
REQ-030 reg_write_address/write_data SHALL hold last value while write=0.
REQ-031 Latency: write 1 cycle after accept (ALU/LINK) or after mem_rvalid (LOAD); register file commits on the negedge of that cycle.

Reset
REQ-032 rst SHALL force IDLE, write=0, reg_write_address=0, write_data=0, mem_err=0, stall_cycles=0, wait counter=0.
REQ-033 rst in WAIT_MEM SHALL abandon the load: no write, no mem_err; rst overrides a same-cycle transfer.

Configuration
REQ-034 Macro WB_SUBWORD_EN defined: little-endian byte/halfword select by latched offset (halfword by offset[1]); LB/LH sign-extend, LBU/LHU zero-extend, LW passes word.
REQ-035 WB_SUBWORD_EN undefined: load write_data = mem_rdata unmodified; in_ltype and offset ignored.

Structure
REQ-036 Package wb_pkg SHALL hold kind enum, ltype enum, FSM state enum, LINK_OFFSET=8.
REQ-037 Combinational sub-module load_extract (word, offset, ltype -> 32-bit data) SHALL be instantiated only under WB_SUBWORD_EN.

Verification
REQ-038 ALU dest=5 result=0xDEADBEEF -> next cycle write=1, addr=5, data=0xDEADBEEF; following cycle write=0.
REQ-039 LINK dest=31 pc=0x00400010 -> write=1, addr=31, data=0x00400018; ALU dest=0 -> write never asserted.
REQ-040 LOAD LB addr=0x1001 dest=8, mem_rvalid after 3 cycles with 0x00008000 -> write data=0xFFFFFF80 (macro on) / 0x00008000 (off); stall_cycles=3; in_ready low throughout.
REQ-041 LOAD with MEM_TIMEOUT=4, no mem_rvalid -> mem_err pulse after 4 wait cycles, no write, in_ready high next; rerun with mem_rvalid on cycle 4 -> write, no mem_err.
REQ-042 rst asserted 2 cycles into WAIT_MEM, mem_rvalid next cycle -> no write, no mem_err, all outputs 0, in_ready=1.
